// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair: frame size, select width and FSM states.
package tdm_pkg;

    // Default number of slots per frame.
    localparam int unsigned TDM_WIDTH = 8;

    // Select width for a given slot count. It is never narrower than one bit,
    // so both ends of the link agree on the width of the select bus.
    function automatic int unsigned selWidth(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    typedef enum logic {
        HUNT,
        RECV
    } tdmState_e;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter shared by the TDM scanner and demux. Clear has priority over load,
// and load has priority over increment. Increment wraps from WIDTH-1 back to 0.
module tdm_slot_cnt import tdm_pkg::*; #(
    parameter int unsigned WIDTH = TDM_WIDTH,
    parameter int unsigned SEL_W = selWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    output logic [SEL_W-1:0] slot
);

    localparam logic [SEL_W-1:0] LastSlot = SEL_W'(WIDTH - 1);

    // Slot index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load) begin
            slot <= SEL_W'(1);
        end else if (inc) begin
            slot <= (slot == LastSlot) ? '0 : slot + SEL_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer. It aligns to the sync marker on slot 0,
// assembles WIDTH slots into a frame and flags alignment violations.
module tdm_demux import tdm_pkg::*; #(
    parameter int unsigned WIDTH = TDM_WIDTH,
    parameter int unsigned SEL_W = selWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic             in_sync,
    output logic [SEL_W-1:0] addr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             locked,
    output logic             frame_err
);

    localparam logic [SEL_W-1:0] LastSlot = SEL_W'(WIDTH - 1);

    tdmState_e        stateQ;
    logic [SEL_W-1:0] slot;
    // The last slot goes straight to out_data, so only WIDTH-1 bits are staged.
    logic [WIDTH-2:0] asmQ;
    logic             isSlot0;
    logic             inRecv;
    logic             clearSlot;
    logic             loadSlot;
    logic             incSlot;

    // Slot counter control, decoded from the same conditions as the FSM below.
    always_comb begin
        isSlot0   = (slot == '0);
        inRecv    = (stateQ == RECV);
        // Any accepted sync restarts a frame at slot 1, in both HUNT and RECV.
        loadSlot  = in_valid && in_sync;
        clearSlot = in_valid && inRecv && isSlot0 && !in_sync;
        incSlot   = in_valid && inRecv && !isSlot0 && !in_sync;
    end

    tdm_slot_cnt #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clearSlot),
        .load  (loadSlot),
        .inc   (incSlot),
        .slot  (slot)
    );

    // The slot counter stays at 0 in HUNT, so it can drive addr directly as a register.
    assign addr   = slot;
    assign locked = inRecv;

    // Alignment FSM, frame assembly and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= HUNT;
            asmQ      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (in_valid) begin
                unique case (stateQ)
                    HUNT: begin
                        if (in_sync) begin
                            asmQ[0] <= in_data;
                            stateQ  <= RECV;
                        end
                    end
                    RECV: begin
                        if (isSlot0) begin
                            if (in_sync) begin
                                asmQ[0] <= in_data;
                            end else begin
                                frame_err <= 1'b1;
                                stateQ    <= HUNT;
                            end
                        end else if (in_sync) begin
                            // Early sync: drop the partial frame and restart at slot 0.
                            frame_err <= 1'b1;
                            asmQ[0]   <= in_data;
                        end else if (slot == LastSlot) begin
                            out_data  <= {in_data, asmQ};
                            out_valid <= 1'b1;
                        end else begin
                            asmQ[slot] <= in_data;
                        end
                    end
                    default: stateQ <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed testbench for tdm_demux (WIDTH = 8).
module tb_tdm_demux;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_data;
    logic       in_sync;
    logic [2:0] addr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       locked;
    logic       frame_err;

    int testsRun = 0;
    int testsFailed = 0;

    tdm_demux #(
        .WIDTH (8),
        .SEL_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .addr      (addr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .locked    (locked),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic sendBit(input logic v, input logic d, input logic s);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_sync  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 1'b0;
        in_sync  = 1'b0;
        #12;
        testsRun++;
        if ({addr, out_data, out_valid, locked, frame_err} !== 14'h0) begin
            testsFailed++;
            $display("FAIL reset_outputs: got addr=%0d data=%h v=%b lk=%b err=%b, want all 0",
                     addr, out_data, out_valid, locked, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sendBit(1'b1, 1'b1, 1'b0);
        testsRun++;
        if (locked !== 1'b0 || addr !== 3'd0) begin
            testsFailed++;
            $display("FAIL hunt_discard: got locked=%b addr=%0d, want 0/0", locked, addr);
        end
    endtask

    task automatic test_aligned();
        logic [7:0] frame;
        frame = 8'h4D;
        for (int i = 0; i < 8; i++) begin
            sendBit(1'b1, frame[i], i == 0);
            testsRun++;
            if (addr !== 3'((i + 1) % 8) || locked !== 1'b1 || out_valid !== (i == 7)
                || frame_err !== 1'b0) begin
                testsFailed++;
                $display("FAIL aligned_slot%0d: got addr=%0d lk=%b v=%b err=%b, want addr=%0d lk=1 v=%b err=0",
                         i, addr, locked, out_valid, frame_err, (i + 1) % 8, i == 7);
            end
        end
        testsRun++;
        if (out_data !== 8'h4D) begin
            testsFailed++;
            $display("FAIL aligned_data: got %h, want 4d", out_data);
        end
        sendBit(1'b0, 1'b0, 1'b0);
        testsRun++;
        if (out_valid !== 1'b0 || out_data !== 8'h4D) begin
            testsFailed++;
            $display("FAIL aligned_strobe_width: got v=%b data=%h, want v=0 data=4d",
                     out_valid, out_data);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] frame;
        frame = 8'h4D;
        for (int i = 0; i < 4; i++) sendBit(1'b1, frame[i], i == 0);
        for (int g = 0; g < 3; g++) begin
            sendBit(1'b0, 1'b1, 1'b1);
            testsRun++;
            if (addr !== 3'd4 || frame_err !== 1'b0 || out_valid !== 1'b0) begin
                testsFailed++;
                $display("FAIL gap_hold%0d: got addr=%0d err=%b v=%b, want 4/0/0",
                         g, addr, frame_err, out_valid);
            end
        end
        for (int i = 4; i < 8; i++) sendBit(1'b1, frame[i], 1'b0);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 8'h4D || frame_err !== 1'b0) begin
            testsFailed++;
            $display("FAIL gap_frame: got v=%b data=%h err=%b, want 1/4d/0",
                     out_valid, out_data, frame_err);
        end
    endtask

    task automatic test_early_sync();
        for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0, i == 0);
        // Sync at slot 5 becomes slot 0 of a new all-ones frame.
        sendBit(1'b1, 1'b1, 1'b1);
        testsRun++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0 || addr !== 3'd1 || locked !== 1'b1
            || out_data !== 8'h4D) begin
            testsFailed++;
            $display("FAIL early_sync_err: got err=%b v=%b addr=%0d lk=%b data=%h, want 1/0/1/1/4d",
                     frame_err, out_valid, addr, locked, out_data);
        end
        sendBit(1'b1, 1'b1, 1'b0);
        testsRun++;
        if (frame_err !== 1'b0 || addr !== 3'd2) begin
            testsFailed++;
            $display("FAIL early_sync_pulse: got err=%b addr=%0d, want 0/2", frame_err, addr);
        end
        for (int i = 2; i < 8; i++) sendBit(1'b1, 1'b1, 1'b0);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || frame_err !== 1'b0) begin
            testsFailed++;
            $display("FAIL early_sync_frame: got v=%b data=%h err=%b, want 1/ff/0",
                     out_valid, out_data, frame_err);
        end
    endtask

    task automatic test_missing_sync();
        sendBit(1'b1, 1'b1, 1'b0);
        testsRun++;
        if (frame_err !== 1'b1 || locked !== 1'b0 || addr !== 3'd0 || out_data !== 8'hFF
            || out_valid !== 1'b0) begin
            testsFailed++;
            $display("FAIL missing_sync: got err=%b lk=%b addr=%0d data=%h v=%b, want 1/0/0/ff/0",
                     frame_err, locked, addr, out_data, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            sendBit(1'b1, 1'b0, 1'b0);
            testsRun++;
            if (frame_err !== 1'b0 || locked !== 1'b0 || addr !== 3'd0 || out_valid !== 1'b0) begin
                testsFailed++;
                $display("FAIL missing_sync_ignore%0d: got err=%b lk=%b addr=%0d v=%b, want 0/0/0/0",
                         i, frame_err, locked, addr, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        int          firstCycle;
        int          pulses;
        bits       = {8'h3C, 8'hA5};
        firstCycle = -1;
        pulses     = 0;
        for (int c = 0; c < 16; c++) begin
            sendBit(1'b1, bits[c], (c % 8) == 0);
            if (out_valid === 1'b1) begin
                pulses++;
                if (firstCycle < 0) begin
                    firstCycle = c;
                    testsRun++;
                    if (out_data !== 8'hA5) begin
                        testsFailed++;
                        $display("FAIL b2b_first: got %h, want a5", out_data);
                    end
                end else begin
                    testsRun++;
                    if (c - firstCycle !== 8 || out_data !== 8'h3C) begin
                        testsFailed++;
                        $display("FAIL b2b_second: got spacing=%0d data=%h, want 8/3c",
                                 c - firstCycle, out_data);
                    end
                end
            end
        end
        testsRun++;
        if (pulses !== 2 || firstCycle !== 7) begin
            testsFailed++;
            $display("FAIL b2b_pulses: got %0d pulses first at %0d, want 2 at 7", pulses, firstCycle);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b1, i == 0);
        testsRun++;
        if (addr !== 3'd4 || locked !== 1'b1) begin
            testsFailed++;
            $display("FAIL areset_pre: got addr=%0d lk=%b, want 4/1", addr, locked);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({addr, out_data, out_valid, locked, frame_err} !== 14'h0) begin
            testsFailed++;
            $display("FAIL areset_now: got addr=%0d data=%h v=%b lk=%b err=%b, want all 0",
                     addr, out_data, out_valid, locked, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) sendBit(1'b1, i == 0, i == 0);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || locked !== 1'b1) begin
            testsFailed++;
            $display("FAIL areset_frame: got v=%b data=%h lk=%b, want 1/01/1",
                     out_valid, out_data, locked);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
